// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, funct codes,
// ALU command codes, datapath mux encodings and the controller state type.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_NOR = 6'b100111;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLL = 4'b1110;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEMADR,
      MEMRD,
      MEMWB,
      MEMWR,
      EXEC,
      ALUWB,
      BRANCH,
      ADDIEX,
      ADDIWB,
      JUMP
   } state_t;

   // Successor of DECODE; FETCH means the instruction is not supported.
   function automatic state_t decode_next(input logic [5:0] op, input logic funct_legal);
      state_t nxt;
      case (op)
         OP_LW, OP_SW: nxt = MEMADR;
         OP_RTYPE:     nxt = funct_legal ? EXEC : FETCH;
         OP_BEQ:       nxt = BRANCH;
         OP_ADDI:      nxt = ADDIEX;
         OP_J:         nxt = JUMP;
         default:      nxt = FETCH;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct decoder: yields the ALU command and whether the
// funct code is one the datapath supports.
module alu_decoder
   import mips_pkg::*;
(
   input  logic [5:0] funct,
   output logic [3:0] alu_control,
   output logic       funct_legal
);

   always_comb begin
      alu_control = ALU_ADD;
      funct_legal = 1'b1;
      case (funct)
         FN_ADD:  alu_control = ALU_ADD;
         FN_SUB:  alu_control = ALU_SUB;
         FN_AND:  alu_control = ALU_AND;
         FN_NOR:  alu_control = ALU_NOR;
         FN_SLT:  alu_control = ALU_SLT;
         FN_SLL:  alu_control = ALU_SLL;
         default: funct_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: steps each instruction through its states and
// drives datapath selects, write enables and the ALU command.
module multicycle_control
   import mips_pkg::*;
#(
   parameter state_t RESET_STATE = FETCH
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [3:0] ALUControl,
   output logic       Illegal
);

   state_t     state;
   logic [3:0] exec_alu;
   logic       funct_legal;
   state_t     decoded_next;
   logic       pc_write;
   logic       pc_write_cond;

   alu_decoder u_alu_decoder (
      .funct       (Funct),
      .alu_control (exec_alu),
      .funct_legal (funct_legal)
   );

   assign decoded_next = decode_next(Op, funct_legal);

   // Memory states hold until MemReady; every other state advances unconditionally.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RESET_STATE;
      end else begin
         case (state)
            FETCH:   if (MemReady) state <= DECODE;
            DECODE:  state <= decoded_next;
            MEMADR:  state <= (Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   if (MemReady) state <= MEMWB;
            MEMWB:   state <= FETCH;
            MEMWR:   if (MemReady) state <= FETCH;
            EXEC:    state <= ALUWB;
            ALUWB:   state <= FETCH;
            BRANCH:  state <= FETCH;
            ADDIEX:  state <= ADDIWB;
            ADDIWB:  state <= FETCH;
            JUMP:    state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      IorD          = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegDst        = 1'b0;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = SRCB_RT;
      PCSrc         = PCSRC_ALU;
      ALUControl    = ALU_ADD;
      Illegal       = 1'b0;
      case (state)
         FETCH: begin
            MemRead  = 1'b1;
            ALUSrcB  = SRCB_FOUR;
            IRWrite  = MemReady;
            pc_write = MemReady;
         end
         // The branch target is precomputed here so BRANCH can take it from ALUOut.
         DECODE: begin
            ALUSrcB = SRCB_IMMSH;
            Illegal = (decoded_next == FETCH);
         end
         MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         EXEC: begin
            ALUSrcA    = 1'b1;
            ALUControl = exec_alu;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            RegDst   = 1'b1;
         end
         BRANCH: begin
            ALUSrcA       = 1'b1;
            ALUControl    = ALU_SUB;
            pc_write_cond = 1'b1;
            PCSrc         = PCSRC_ALUOUT;
         end
         ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         ADDIWB: RegWrite = 1'b1;
         JUMP: begin
            pc_write = 1'b1;
            PCSrc    = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign PCEn = pc_write | (pc_write_cond & Zero);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected output words are queued as
// each cycle is driven and compared when that cycle is sampled.
module tb_multicycle_control;

   localparam int S_FETCH  = 0;
   localparam int S_DECODE = 1;
   localparam int S_MEMADR = 2;
   localparam int S_MEMRD  = 3;
   localparam int S_MEMWB  = 4;
   localparam int S_MEMWR  = 5;
   localparam int S_EXEC   = 6;
   localparam int S_ALUWB  = 7;
   localparam int S_BRANCH = 8;
   localparam int S_ADDIEX = 9;
   localparam int S_ADDIWB = 10;
   localparam int S_JUMP   = 11;

   localparam logic [5:0] OPC_R    = 6'b000000;
   localparam logic [5:0] OPC_LW   = 6'b100011;
   localparam logic [5:0] OPC_SW   = 6'b101011;
   localparam logic [5:0] OPC_BEQ  = 6'b000100;
   localparam logic [5:0] OPC_ADDI = 6'b001000;
   localparam logic [5:0] OPC_J    = 6'b000010;
   localparam logic [5:0] OPC_BAD  = 6'b111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op_in;
   logic [5:0] funct_in;
   logic       zero_in;
   logic       mem_ready;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, memto_reg, reg_write;
   logic       alu_src_a, illegal;
   logic [1:0] alu_src_b, pc_src;
   logic [3:0] alu_control;
   logic [17:0] obs_vec;

   logic [17:0] exp_q[$];
   string       tag_q[$];
   int          check_count = 0;
   int          pass_count  = 0;
   int          fail_count  = 0;

   multicycle_control dut (
      .clk        (clk),
      .reset      (reset),
      .Op         (op_in),
      .Funct      (funct_in),
      .Zero       (zero_in),
      .MemReady   (mem_ready),
      .PCEn       (pc_en),
      .IorD       (iord),
      .MemRead    (mem_read),
      .MemWrite   (mem_write),
      .IRWrite    (ir_write),
      .RegDst     (reg_dst),
      .MemtoReg   (memto_reg),
      .RegWrite   (reg_write),
      .ALUSrcA    (alu_src_a),
      .ALUSrcB    (alu_src_b),
      .PCSrc      (pc_src),
      .ALUControl (alu_control),
      .Illegal    (illegal)
   );

   always #5 clk = ~clk;

   assign obs_vec = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, memto_reg,
                     reg_write, alu_src_a, alu_src_b, pc_src, alu_control, illegal};

   // Reference output word for a state, written straight from the state table.
   function automatic logic [17:0] expectVec(input int st, input logic mr, input logic z,
                                             input logic [3:0] exec_alu, input logic ill);
      logic e_pcen, e_iord, e_mrd, e_mwr, e_irw, e_dst, e_m2r, e_rw, e_srca, e_ill;
      logic [1:0] e_srcb, e_pcsrc;
      logic [3:0] e_alu;
      {e_pcen, e_iord, e_mrd, e_mwr, e_irw, e_dst, e_m2r, e_rw, e_srca, e_ill} = '0;
      e_srcb  = 2'b00;
      e_pcsrc = 2'b00;
      e_alu   = 4'b0010;
      case (st)
         S_FETCH:  begin e_mrd = 1'b1; e_srcb = 2'b01; e_pcen = mr; e_irw = mr; end
         S_DECODE: begin e_srcb = 2'b11; e_ill = ill; end
         S_MEMADR: begin e_srca = 1'b1; e_srcb = 2'b10; end
         S_MEMRD:  begin e_mrd = 1'b1; e_iord = 1'b1; end
         S_MEMWB:  begin e_rw = 1'b1; e_m2r = 1'b1; end
         S_MEMWR:  begin e_mwr = 1'b1; e_iord = 1'b1; end
         S_EXEC:   begin e_srca = 1'b1; e_alu = exec_alu; end
         S_ALUWB:  begin e_rw = 1'b1; e_dst = 1'b1; end
         S_BRANCH: begin e_srca = 1'b1; e_alu = 4'b0110; e_pcsrc = 2'b01; e_pcen = z; end
         S_ADDIEX: begin e_srca = 1'b1; e_srcb = 2'b10; end
         S_ADDIWB: e_rw = 1'b1;
         S_JUMP:   begin e_pcen = 1'b1; e_pcsrc = 2'b10; end
         default:  ;
      endcase
      return {e_pcen, e_iord, e_mrd, e_mwr, e_irw, e_dst, e_m2r, e_rw, e_srca,
              e_srcb, e_pcsrc, e_alu, e_ill};
   endfunction

   task automatic applyStimulus(input string tag, input logic [5:0] op, input logic [5:0] fn,
                                input logic mr, input logic z, input logic [17:0] exp_word);
      op_in     = op;
      funct_in  = fn;
      mem_ready = mr;
      zero_in   = z;
      tag_q.push_back(tag);
      exp_q.push_back(exp_word);
   endtask

   task automatic checkOutput(input bit on_edge);
      string       tag;
      logic [17:0] exp_word;
      if (on_edge) @(negedge clk);
      tag      = tag_q.pop_front();
      exp_word = exp_q.pop_front();
      check_count++;
      assert (obs_vec === exp_word) pass_count++;
      else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%b required=%b", tag, obs_vec, exp_word);
      end
      if (on_edge) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic runCycle(input string tag, input logic [5:0] op, input logic [5:0] fn,
                           input logic mr, input logic z, input int st,
                           input logic [3:0] exec_alu, input logic ill);
      applyStimulus(tag, op, fn, mr, z, expectVec(st, mr, z, exec_alu, ill));
      checkOutput(1'b1);
   endtask

   // MemReady is deliberately low outside FETCH to show it is ignored there.
   task automatic runRType(input string tag, input logic [5:0] fn, input logic [3:0] exp_alu);
      runCycle({tag, "_fetch"},  OPC_R, fn, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle({tag, "_decode"}, OPC_R, fn, 1'b0, 1'b0, S_DECODE, 4'b0010, 1'b0);
      runCycle({tag, "_exec"},   OPC_R, fn, 1'b0, 1'b0, S_EXEC,   exp_alu, 1'b0);
      runCycle({tag, "_wb"},     OPC_R, fn, 1'b0, 1'b0, S_ALUWB,  4'b0010, 1'b0);
   endtask

   initial begin
      reset     = 1'b1;
      op_in     = OPC_R;
      funct_in  = 6'b100000;
      zero_in   = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus("reset_ready", OPC_R, 6'b100000, 1'b1, 1'b0, expectVec(S_FETCH, 1'b1, 1'b0, 4'b0010, 1'b0));
      checkOutput(1'b0);
      applyStimulus("reset_wait", OPC_R, 6'b100000, 1'b0, 1'b1, expectVec(S_FETCH, 1'b0, 1'b1, 4'b0010, 1'b0));
      #1;
      checkOutput(1'b0);
      reset = 1'b0;

      runRType("add", 6'b100000, 4'b0010);
      runRType("sll", 6'b000000, 4'b1110);
      runRType("sub", 6'b100010, 4'b0110);
      runRType("and", 6'b100100, 4'b0000);
      runRType("nor", 6'b100111, 4'b1100);
      runRType("slt", 6'b101010, 4'b0111);

      $display("[TB] lw with fetch wait and three MEMRD waits");
      runCycle("lw_fetch_wait", OPC_LW, 6'h05, 1'b0, 1'b1, S_FETCH,  4'b0010, 1'b0);
      runCycle("lw_fetch",      OPC_LW, 6'h05, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("lw_decode",     OPC_LW, 6'h05, 1'b1, 1'b0, S_DECODE, 4'b0010, 1'b0);
      runCycle("lw_memadr",     OPC_LW, 6'h05, 1'b0, 1'b0, S_MEMADR, 4'b0010, 1'b0);
      for (int i = 0; i < 3; i++)
         runCycle("lw_memrd_wait", OPC_LW, 6'h05, 1'b0, 1'b0, S_MEMRD, 4'b0010, 1'b0);
      runCycle("lw_memrd",      OPC_LW, 6'h05, 1'b1, 1'b0, S_MEMRD,  4'b0010, 1'b0);
      runCycle("lw_memwb",      OPC_LW, 6'h05, 1'b0, 1'b0, S_MEMWB,  4'b0010, 1'b0);

      runCycle("sw_fetch",  OPC_SW, 6'h10, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("sw_decode", OPC_SW, 6'h10, 1'b1, 1'b0, S_DECODE, 4'b0010, 1'b0);
      runCycle("sw_memadr", OPC_SW, 6'h10, 1'b1, 1'b0, S_MEMADR, 4'b0010, 1'b0);
      runCycle("sw_memwr",  OPC_SW, 6'h10, 1'b1, 1'b0, S_MEMWR,  4'b0010, 1'b0);

      runCycle("addi_fetch",  OPC_ADDI, 6'h22, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("addi_decode", OPC_ADDI, 6'h22, 1'b0, 1'b0, S_DECODE, 4'b0010, 1'b0);
      runCycle("addi_ex",     OPC_ADDI, 6'h22, 1'b0, 1'b0, S_ADDIEX, 4'b0010, 1'b0);
      runCycle("addi_wb",     OPC_ADDI, 6'h22, 1'b0, 1'b0, S_ADDIWB, 4'b0010, 1'b0);

      runCycle("j_fetch",  OPC_J, 6'h00, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("j_decode", OPC_J, 6'h00, 1'b1, 1'b0, S_DECODE, 4'b0010, 1'b0);
      runCycle("j_jump",   OPC_J, 6'h00, 1'b0, 1'b0, S_JUMP,   4'b0010, 1'b0);

      runCycle("beq_t_fetch",  OPC_BEQ, 6'h01, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("beq_t_decode", OPC_BEQ, 6'h01, 1'b1, 1'b1, S_DECODE, 4'b0010, 1'b0);
      runCycle("beq_taken",    OPC_BEQ, 6'h01, 1'b0, 1'b1, S_BRANCH, 4'b0010, 1'b0);
      runCycle("beq_n_fetch",  OPC_BEQ, 6'h01, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("beq_n_decode", OPC_BEQ, 6'h01, 1'b1, 1'b0, S_DECODE, 4'b0010, 1'b0);
      runCycle("beq_not_taken", OPC_BEQ, 6'h01, 1'b1, 1'b0, S_BRANCH, 4'b0010, 1'b0);

      runCycle("ill_fn_fetch",  OPC_R, 6'b100101, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("ill_fn_decode", OPC_R, 6'b100101, 1'b1, 1'b0, S_DECODE, 4'b0010, 1'b1);
      runCycle("ill_op_fetch",  OPC_BAD, 6'b100000, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("ill_op_decode", OPC_BAD, 6'b100000, 1'b1, 1'b0, S_DECODE, 4'b0010, 1'b1);

      $display("[TB] reset asserted while MEMWR waits");
      runCycle("rst_sw_fetch",  OPC_SW, 6'h10, 1'b1, 1'b0, S_FETCH,  4'b0010, 1'b0);
      runCycle("rst_sw_decode", OPC_SW, 6'h10, 1'b1, 1'b0, S_DECODE, 4'b0010, 1'b0);
      runCycle("rst_sw_memadr", OPC_SW, 6'h10, 1'b1, 1'b0, S_MEMADR, 4'b0010, 1'b0);
      runCycle("rst_sw_memwr",  OPC_SW, 6'h10, 1'b0, 1'b0, S_MEMWR,  4'b0010, 1'b0);
      #2;
      reset = 1'b1;
      applyStimulus("rst_abort_memwr", OPC_SW, 6'h10, 1'b0, 1'b0, expectVec(S_FETCH, 1'b0, 1'b0, 4'b0010, 1'b0));
      #1;
      checkOutput(1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      runRType("post_rst_add", 6'b100000, 4'b0010);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multicycle MIPS control unit: sequences each instruction through fetch, decode, execute, memory and writeback states. Drives the datapath muxes, register-file and memory enables, and the 4-bit `ALUControl` code consumed by the ALU. It is the command-producing end of the ALU interface. It also consumes the ALU's `zero` flag to resolve `beq`, and waits on a memory ready handshake.

## Interface
- `RESET_STATE`, default `FETCH`: state entered on reset (fixed; not overridable in practice).
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; forces state to `FETCH`.
- `Op` input 6: instruction[31:26] from the IR.
- `Funct` input 6: instruction[5:0] from the IR.
- `Zero` input 1: ALU `zero` flag (valid only while `ALUControl` = SUB).
- `MemReady` input 1: memory has completed the current read or write this cycle.
- `PCEn` output 1: PC load enable, equal to `PCWrite | (PCWriteCond & Zero)`.
- `IorD` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead` output 1: memory read request.
- `MemWrite` output 1: memory write request.
- `IRWrite` output 1: instruction-register load.
- `RegDst` output 1: destination select; 1 = rd, 0 = rt.
- `MemtoReg` output 1: writeback data select; 1 = MDR.
- `RegWrite` output 1: register-file write enable.
- `ALUSrcA` output 1: 0 = PC, 1 = rs.
- `ALUSrcB` output 2: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `PCSrc` output 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUControl` output 4: AND 0000, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1110.
- `Illegal` output 1: one-cycle pulse on an unsupported Op/Funct.

## Operation
- Outputs are Moore functions of state. Exceptions: in EXEC, `ALUControl` is decoded from `Funct`; `PCEn`, `IRWrite` and the memory states are qualified by `MemReady`/`Zero`.
- Every output not listed for a state is 0. In every state not listed below, `ALUControl` = ADD.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type funct codes: add 100000, sub 100010, and 100100, nor 100111, slt 101010, sll 000000. An all-zero instruction therefore executes as sll $0, a no-op.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `PCSrc`=00.
  - `IRWrite` and `PCWrite` are asserted only while `MemReady`=1.
  - Stay in FETCH until `MemReady`=1, then go to DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, ALU = ADD (branch target into ALUOut). Next state by opcode:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - addi → ADDIEX
  - j → JUMP
  - any other opcode, or R-type with an unsupported funct (e.g. or, 100101) → `Illegal`=1, then FETCH. No register or memory write occurs.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Go to MEMRD (lw) or MEMWR (sw).
- MEMRD: `MemRead`=1, `IorD`=1. Wait for `MemReady`, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Then FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Wait for `MemReady`, then go to FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUControl` decoded from `Funct`. Then ALUWB.
- ALUWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Then FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, SUB, `PCWriteCond`=1, `PCSrc`=01. Then FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Then ADDIWB.
- ADDIWB: `RegWrite`=1, `RegDst`=0. Then FETCH.
- JUMP: `PCWrite`=1, `PCSrc`=10. Then FETCH.

## Timing
- Reset (asynchronous, takes effect immediately): state = FETCH. Outputs during reset are the FETCH values:
  - `MemRead`=1, `ALUSrcB`=01, `ALUControl`=0010, all other outputs 0.
  - `PCEn`=`IRWrite`=`MemReady`, since `MemReady` still qualifies them.
- Reset asserted mid-instruction aborts it immediately: no write strobe survives past the reset edge, and the next instruction restarts at FETCH.
- Cycle counts with `MemReady` tied to 1:
  - R-type 4, lw 5, sw 4, addi 4, beq 3, j 3.
  - An illegal instruction takes 2 (FETCH, DECODE).
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `MemRead`/`MemWrite` and their address select are held stable throughout a wait.
- `MemReady` is ignored in every non-memory state.
- `Zero` is sampled combinationally in BRANCH only.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants;
  - `ALUControl` codes (AND, ADD, SUB, SLT, NOR, SLL);
  - the ALUSrcB and PCSrc encodings;
  - the state enum (12 states).
- Sub-module `alu_decoder`: purely combinational Funct → {ALUControl, funct-legal}. It is used by EXEC and by the illegal-instruction check in DECODE.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- **Reset:** assert `reset` mid-MEMWR (`MemWrite`=1) → `MemWrite` drops the same cycle; state = FETCH; `ALUControl`=0010.
- **R-type add** (Op 000000, Funct 100000), `MemReady`=1 → states FETCH, DECODE, EXEC, ALUWB. `ALUControl`=0010 in EXEC; `RegWrite`=`RegDst`=1 in cycle 4.
- **lw with 3 wait cycles in MEMRD** → `MemRead`=`IorD`=1 held for 4 cycles; `RegWrite`=`MemtoReg`=1 exactly once; 8 cycles total.
- **beq taken and not taken:**
  - `Zero`=1 in BRANCH → `PCEn`=1, `PCSrc`=01, `ALUControl`=0110.
  - `Zero`=0 → `PCEn`=0.
- **Illegal instruction** (R-type Funct 100101, or Op 111111) → `Illegal` pulses for 1 cycle in DECODE; no `RegWrite`/`MemWrite`; FETCH follows.
- **Decoder coverage:** sll, sub, and, nor, slt → `ALUControl` 1110, 0110, 0000, 1100, 0111 in EXEC respectively.
